// File: rtl/e17_mon_pkg.sv
// Shared encodings for the e17 output monitor: tracked-state enum and the
// y-bus patterns (bit k of a pattern corresponds to output yk).
package e17_mon_pkg;

  typedef enum logic [3:0] {
    UNK = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11
  } state_t;

  // One bit per state encoding; bit 0 (UNK) is never a legal source.
  typedef logic [11:0] src_mask_t;

  function automatic logic [17:1] ybit(input int k);
    return 17'(1) << (k - 1);
  endfunction

  function automatic src_mask_t smask(input state_t s);
    return src_mask_t'(1) << s;
  endfunction

  localparam logic [17:1] Y_S2_A  = ybit(7) | ybit(9) | ybit(15);
  localparam logic [17:1] Y_S2_B  = ybit(1) | ybit(9) | ybit(14) | ybit(15);
  localparam logic [17:1] Y_S3    = ybit(1) | ybit(8) | ybit(9);
  localparam logic [17:1] Y_S4    = ybit(1) | ybit(2) | ybit(3);
  localparam logic [17:1] Y_S5    = ybit(10) | ybit(11);
  localparam logic [17:1] Y_S6    = ybit(2) | ybit(10);
  localparam logic [17:1] Y_S7_A  = ybit(4);
  localparam logic [17:1] Y_S7_B  = ybit(5);
  localparam logic [17:1] Y_S8    = ybit(16);
  localparam logic [17:1] Y_S9_A  = ybit(6);
  localparam logic [17:1] Y_S9_B  = ybit(13);
  localparam logic [17:1] Y_S10   = ybit(1);
  localparam logic [17:1] Y_S11   = ybit(8) | ybit(9) | ybit(17);
  localparam logic [17:1] Y_S1    = ybit(12);

endpackage

// File: rtl/e17_pat_decode.sv
// Combinational classifier: maps a y-bus pattern to its destination state
// and the set of states it may legally be emitted from.
module e17_pat_decode
  import e17_mon_pkg::*;
(
  input  logic [17:1] y,
  output logic        valid,
  output state_t      dst,
  output src_mask_t   src
);

  always_comb begin
    valid = 1'b1;
    dst   = UNK;
    src   = '0;
    case (y)
      Y_S2_A:         begin dst = S2;  src = smask(S1) | smask(S7); end
      Y_S2_B:         begin dst = S2;  src = smask(S5) | smask(S6); end
      Y_S3:           begin dst = S3;  src = smask(S1) | smask(S7) | smask(S10); end
      Y_S4:           begin dst = S4;  src = smask(S1) | smask(S5); end
      Y_S5:           begin dst = S5;  src = smask(S1) | smask(S3); end
      Y_S6:           begin dst = S6;  src = smask(S1) | smask(S7); end
      Y_S7_A, Y_S7_B: begin dst = S7;  src = smask(S1) | smask(S3) | smask(S4) | smask(S5); end
      Y_S8:           begin dst = S8;  src = smask(S2) | smask(S9); end
      Y_S9_A:         begin dst = S9;  src = smask(S3); end
      Y_S9_B:         begin dst = S9;  src = smask(S5) | smask(S6); end
      Y_S10:          begin dst = S10; src = smask(S7); end
      Y_S11:          begin dst = S11; src = smask(S8); end
      Y_S1:           begin dst = S1;  src = smask(S11); end
      default:        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/e17_out_monitor.sv
// Passive monitor for the e17 FSM: tracks its state from observed y/x on the
// falling edge, flags illegal patterns and suppressed s10 payloads.
module e17_out_monitor
  import e17_mon_pkg::*;
#(
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [8:1]       x,
  input  logic [17:1]      y,
  output logic [3:0]       state_est,
  output logic             pat_err,
  output logic             sup_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm
);

  state_t          state_q;
  state_t          state_d;
  logic            pat_d;
  logic            sup_d;
  logic [CNT_W-1:0] cnt_d;
  logic            code_valid;
  state_t          code_dst;
  src_mask_t       code_src;
  logic            unused_x;

  assign unused_x  = ^{x[7:4], x[2]};
  assign state_est = state_q;

  e17_pat_decode u_decode (
    .y     (y),
    .valid (code_valid),
    .dst   (code_dst),
    .src   (code_src)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = 1'b0;
    sup_d   = 1'b0;
    if (y != '0) begin
      if (code_valid) begin
        state_d = code_dst;
        pat_d   = (state_q != UNK) && !code_src[state_q];
      end else begin
        state_d = UNK;
        pat_d   = 1'b1;
      end
    end else begin
      // Idle cycles only carry meaning in states whose exit depends on x.
      case (state_q)
        S3:  if (!x[8]) state_d = S1;
        S7:  if (!x[8] && !x[1] && x[3]) state_d = S1;
        S10: begin
          if (x[3]) begin
            state_d = S1;
          end else begin
            state_d = S3;
            sup_d   = 1'b1;
          end
        end
        S8, S9: begin
          state_d = UNK;
          pat_d   = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
    cnt_d = err_cnt;
    if ((pat_d || sup_d) && (err_cnt != '1))
      cnt_d = err_cnt + CNT_W'(1);
  end

  // Everything, pulses included, freezes while en is low.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S1;
      pat_err <= 1'b0;
      sup_err <= 1'b0;
      err_cnt <= '0;
      alarm   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      pat_err <= pat_d;
      sup_err <= sup_d;
      err_cnt <= cnt_d;
      alarm   <= alarm | (int'(cnt_d) >= ERR_THRESH);
    end
  end

endmodule
